uart_rx_fifo: RTL and testbench

Parametrised UART receiver, the successor to the fixed 8N1 receiver. Data width, parity mode and stop-bit count are set by parameters, and the baud divisor is set at run time. Each bit is decided by a 3-sample majority vote. Received words, with per-word error flags, are buffered in a small FIFO. The block sits between the pad-level rx line and the CPU/bus-side peripheral register logic.

---
 rtl/uart_rx_fifo.sv | 218 +++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Oversampled UART receiver (3-sample majority vote) feeding a small word FIFO; optional idle timeout under UART_RX_TIMEOUT_EN.
// Latency: word visible on o_avail one cycle after the final stop-bit vote; head outputs are combinational from storage.
// Backpressure: none toward the line; a word arriving while the FIFO is full is dropped and o_overrun latches.
module uart_rx_fifo #(
    parameter int DATA_BITS = 8,
    parameter int OVERSAMP  = 16,
    parameter int DIV_W     = 16,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int FIFO_LOG2 = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_rx,
    input  logic [DIV_W-1:0]     i_div,
    input  logic                 i_ack,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_avail,
    output logic                 o_overrun,
    output logic                 o_break,
    output logic                 o_busy,
    output logic                 o_timeout
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;
    localparam logic [2:0] S_BRK   = 3'd5;

    localparam int OS_W = $clog2(OVERSAMP);
    localparam logic [OS_W-1:0] OS_V0   = OS_W'(OVERSAMP/2 - 1);
    localparam logic [OS_W-1:0] OS_V1   = OS_W'(OVERSAMP/2);
    localparam logic [OS_W-1:0] OS_V2   = OS_W'(OVERSAMP/2 + 1);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMP - 1);
    localparam logic [3:0]      LAST_BIT = 4'(DATA_BITS - 1);
    localparam logic            ODD   = (PARITY == 1);
    localparam logic            STOP2 = (STOP_BITS == 2);
    localparam int              WW    = DATA_BITS + 2;
    localparam int              DEPTH = 2**FIFO_LOG2;

    logic                 rx_meta, r_rx;
    logic [DIV_W-1:0]     div_lat, div_cnt;
    logic [OS_W-1:0]      os;
    logic                 samp0, samp1;
    logic [2:0]           state;
    logic [3:0]           bit_cnt;
    logic                 stop_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr, ferr, nonzero, brk;

    logic tick, mid, bit_end, vote, last_stop, is_break, push;
    logic [WW-1:0] push_word;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_meta <= 1'b1;
            r_rx    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            r_rx    <= rx_meta;
        end
    end

    assign tick      = (div_cnt == div_lat);
    assign mid       = tick && (os == OS_V2);
    assign bit_end   = tick && (os == OS_LAST);
    assign vote      = (samp0 & samp1) | (samp0 & r_rx) | (samp1 & r_rx);
    assign last_stop = !STOP2 || stop_cnt;
    // Break: every data/parity vote and the final stop vote were all 0
    assign is_break  = !nonzero && !vote;
    assign push      = (state == S_STOP) && mid && last_stop && !is_break;
    assign push_word = {perr, ferr | ~vote, shreg};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= S_IDLE;
            div_lat  <= '0;
            div_cnt  <= '0;
            os       <= '0;
            samp0    <= 1'b0;
            samp1    <= 1'b0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            shreg    <= '0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
            nonzero  <= 1'b0;
            brk      <= 1'b0;
        end else begin
            brk <= 1'b0;
            if (state == S_IDLE && !r_rx) begin
                div_lat  <= i_div;
                div_cnt  <= '0;
                os       <= '0;
                bit_cnt  <= '0;
                stop_cnt <= 1'b0;
                perr     <= 1'b0;
                ferr     <= 1'b0;
                nonzero  <= 1'b0;
                state    <= S_START;
            end else begin
                div_cnt <= tick ? '0 : div_cnt + 1'b1;
                if (tick) begin
                    os <= (os == OS_LAST) ? '0 : os + 1'b1;
                    if (os == OS_V0) samp0 <= r_rx;
                    if (os == OS_V1) samp1 <= r_rx;
                end
                case (state)
                    S_IDLE: ;
                    S_START: begin
                        if (mid && vote)  state <= S_IDLE;
                        else if (bit_end) state <= S_DATA;
                    end
                    S_DATA: begin
                        if (mid) begin
                            shreg <= {vote, shreg[DATA_BITS-1:1]};
                            if (vote) nonzero <= 1'b1;
                        end
                        if (bit_end) begin
                            if (bit_cnt == LAST_BIT) state <= (PARITY != 0) ? S_PAR : S_STOP;
                            else                     bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    S_PAR: begin
                        if (mid) begin
                            perr <= (^shreg) ^ vote ^ ODD;
                            if (vote) nonzero <= 1'b1;
                        end else if (bit_end) begin
                            state <= S_STOP;
                        end
                    end
                    S_STOP: begin
                        if (mid) begin
                            if (!vote) ferr <= 1'b1;
                            if (last_stop) begin
                                state <= is_break ? S_BRK : S_IDLE;
                                brk   <= is_break;
                            end
                        end else if (bit_end) begin
                            stop_cnt <= 1'b1;
                        end
                    end
                    S_BRK: if (r_rx) state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    logic [WW-1:0]      mem [DEPTH];
    logic [FIFO_LOG2:0] wptr, rptr;
    logic               empty, full, pop, wr, overrun;
    logic [WW-1:0]      head;

    assign empty = (wptr == rptr);
    assign full  = (wptr[FIFO_LOG2] != rptr[FIFO_LOG2]) &&
                   (wptr[FIFO_LOG2-1:0] == rptr[FIFO_LOG2-1:0]);
    assign pop   = i_ack && !empty;
    assign wr    = push && (!full || pop);
    assign head  = mem[rptr[FIFO_LOG2-1:0]];

    always_ff @(posedge i_clk) begin
        if (wr) mem[wptr[FIFO_LOG2-1:0]] <= push_word;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wptr    <= '0;
            rptr    <= '0;
            overrun <= 1'b0;
        end else begin
            if (wr)  wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            if (push && full && !pop) overrun <= 1'b1;
            else if (pop)             overrun <= 1'b0;
        end
    end

    // Stale storage is masked so every head output reads 0 while empty
    assign o_data       = empty ? '0 : head[DATA_BITS-1:0];
    assign o_frame_err  = !empty && head[DATA_BITS];
    assign o_parity_err = !empty && head[DATA_BITS+1];
    assign o_avail      = !empty;
    assign o_overrun    = overrun;
    assign o_break      = brk;
    assign o_busy       = (state != S_IDLE);

`ifdef UART_RX_TIMEOUT_EN
    localparam int TO_LIMIT = 4 * (DATA_BITS + 2) * OVERSAMP;
    localparam int TO_W     = $clog2(TO_LIMIT + 1);
    logic [TO_W-1:0] idle_cnt;
    logic            timeout, to_clr;

    assign to_clr = (state == S_IDLE && !r_rx) || push || pop;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            idle_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= 1'b0;
            if (to_clr) begin
                idle_cnt <= '0;
            end else if (tick && state == S_IDLE && r_rx && !empty &&
                         idle_cnt != TO_W'(TO_LIMIT)) begin
                idle_cnt <= idle_cnt + 1'b1;
                timeout  <= (idle_cnt == TO_W'(TO_LIMIT - 1));
            end
        end
    end
    assign o_timeout = timeout;
`else
    assign o_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench: 8N1 instance plus an even-parity instance, both at i_div=1 (32 clocks per bit).
module tb_uart_rx_fifo;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rx, rx_p, ack, ack_p;
    logic [15:0] div;
    logic [7:0]  data, data_p;
    logic        perr, ferr, avail, overrun, brk, busy, tmo;
    logic        perr_p, ferr_p, avail_p, overrun_p, brk_p, busy_p, tmo_p;

    int checks = 0;
    int errors = 0;
    int brk_cycles = 0;
    int tmo_cycles = 0;

    uart_rx_fifo #(.DATA_BITS(8), .OVERSAMP(16), .DIV_W(16), .PARITY(0), .STOP_BITS(1), .FIFO_LOG2(2)) dut (
        .i_clk(clk), .i_rst(rst), .i_rx(rx), .i_div(div), .i_ack(ack),
        .o_data(data), .o_parity_err(perr), .o_frame_err(ferr), .o_avail(avail),
        .o_overrun(overrun), .o_break(brk), .o_busy(busy), .o_timeout(tmo));

    uart_rx_fifo #(.DATA_BITS(8), .OVERSAMP(16), .DIV_W(16), .PARITY(2), .STOP_BITS(1), .FIFO_LOG2(2)) dut_p (
        .i_clk(clk), .i_rst(rst), .i_rx(rx_p), .i_div(div), .i_ack(ack_p),
        .o_data(data_p), .o_parity_err(perr_p), .o_frame_err(ferr_p), .o_avail(avail_p),
        .o_overrun(overrun_p), .o_break(brk_p), .o_busy(busy_p), .o_timeout(tmo_p));

    always @(negedge clk) begin
        if (brk || brk_p) brk_cycles++;
        if (tmo || tmo_p) tmo_cycles++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    task automatic drive_bit(input logic sel, input logic v);
        if (sel) rx_p = v; else rx = v;
        repeat (32) @(negedge clk);
    endtask

    task automatic send_frame(input logic sel, input logic [7:0] d, input logic has_par,
                              input logic par, input logic stop);
        drive_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
        if (has_par) drive_bit(sel, par);
        drive_bit(sel, stop);
        if (sel) rx_p = 1'b1; else rx = 1'b1;
    endtask

    task automatic idle_bits(input int n);
        repeat (n * 32) @(negedge clk);
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rx = 1'b1; rx_p = 1'b1; ack = 1'b0; ack_p = 1'b0; div = 16'd1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (avail !== 1'b0)   begin errors++; $display("FAIL rst_avail got %0b want 0", avail); end
        checks++; if (data !== 8'h00)   begin errors++; $display("FAIL rst_data got %h want 00", data); end
        checks++; if ({perr, ferr, overrun, brk, busy, tmo} !== 6'b0)
            begin errors++; $display("FAIL rst_flags got %b want 000000", {perr, ferr, overrun, brk, busy, tmo}); end
        checks++; if (avail_p !== 1'b0) begin errors++; $display("FAIL rst_avail_p got %0b want 0", avail_p); end
    endtask

    task automatic test_basic();
        send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
        checks++; if (avail !== 1'b1)  begin errors++; $display("FAIL a5_avail got %0b want 1", avail); end
        checks++; if (data !== 8'hA5)  begin errors++; $display("FAIL a5_data got %h want a5", data); end
        checks++; if ({perr, ferr} !== 2'b00) begin errors++; $display("FAIL a5_flags got %b want 00", {perr, ferr}); end
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL a5_busy got %0b want 0", busy); end
        pulse_ack();
        checks++; if (avail !== 1'b0)  begin errors++; $display("FAIL a5_pop got %0b want 0", avail); end
    endtask

    task automatic test_parity();
        send_frame(1'b1, 8'h03, 1'b1, 1'b1, 1'b1);
        checks++; if (data_p !== 8'h03) begin errors++; $display("FAIL par_data got %h want 03", data_p); end
        checks++; if (perr_p !== 1'b1)  begin errors++; $display("FAIL par_err got %0b want 1", perr_p); end
        checks++; if (ferr_p !== 1'b0)  begin errors++; $display("FAIL par_ferr got %0b want 0", ferr_p); end
        ack_p = 1'b1; @(negedge clk); ack_p = 1'b0;
        send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
        checks++; if (data_p !== 8'h07) begin errors++; $display("FAIL par_ok_data got %h want 07", data_p); end
        checks++; if (perr_p !== 1'b0)  begin errors++; $display("FAIL par_ok_err got %0b want 0", perr_p); end
        ack_p = 1'b1; @(negedge clk); ack_p = 1'b0;
        checks++; if (avail_p !== 1'b0) begin errors++; $display("FAIL par_pop got %0b want 0", avail_p); end
    endtask

    task automatic test_frame_err();
        send_frame(1'b0, 8'h96, 1'b0, 1'b0, 1'b0);
        checks++; if (data !== 8'h96) begin errors++; $display("FAIL ferr_data got %h want 96", data); end
        checks++; if ({perr, ferr} !== 2'b01) begin errors++; $display("FAIL ferr_flags got %b want 01", {perr, ferr}); end
        idle_bits(2);
        pulse_ack();
        checks++; if (avail !== 1'b0) begin errors++; $display("FAIL ferr_stray_push got %0b want 0", avail); end
    endtask

    task automatic test_glitch();
        int b0;
        int waited;
        b0 = brk_cycles;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy got %0b want 1", busy); end
        repeat (2) @(negedge clk);
        rx = 1'b1;
        waited = 0;
        while (busy === 1'b1 && waited < 26) begin
            @(negedge clk);
            waited++;
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_idle got busy %0b want 0", busy); end
        checks++; if ({avail, perr, ferr, overrun} !== 4'b0)
            begin errors++; $display("FAIL glitch_flags got %b want 0000", {avail, perr, ferr, overrun}); end
        checks++; if (brk_cycles !== b0) begin errors++; $display("FAIL glitch_brk got %0d want %0d", brk_cycles, b0); end
    endtask

    task automatic test_break();
        int b0;
        b0 = brk_cycles;
        rx = 1'b0;
        idle_bits(12);
        checks++; if (brk_cycles - b0 !== 1) begin errors++; $display("FAIL brk_pulses got %0d want 1", brk_cycles - b0); end
        checks++; if (avail !== 1'b0) begin errors++; $display("FAIL brk_avail got %0b want 0", avail); end
        checks++; if (busy !== 1'b1)  begin errors++; $display("FAIL brk_hold got busy %0b want 1", busy); end
        rx = 1'b1;
        idle_bits(2);
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL brk_release got busy %0b want 0", busy); end
        send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
        checks++; if (data !== 8'h5A) begin errors++; $display("FAIL brk_next_data got %h want 5a", data); end
        checks++; if ({avail, perr, ferr} !== 3'b100) begin errors++; $display("FAIL brk_next_flags got %b want 100", {avail, perr, ferr}); end
        pulse_ack();
    endtask

    task automatic test_back_to_back_overrun();
        logic [7:0] want;
        for (int i = 0; i < 5; i++) send_frame(1'b0, 8'h11 + 8'(i), 1'b0, 1'b0, 1'b1);
        idle_bits(1);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got %0b want 1", overrun); end
        for (int i = 0; i < 4; i++) begin
            want = 8'h11 + 8'(i);
            checks++; if (avail !== 1'b1) begin errors++; $display("FAIL ovr_avail%0d got %0b want 1", i, avail); end
            checks++; if (data !== want)  begin errors++; $display("FAIL ovr_head%0d got %h want %h", i, data, want); end
            pulse_ack();
            checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear%0d got %0b want 0", i, overrun); end
        end
        checks++; if (avail !== 1'b0) begin errors++; $display("FAIL ovr_lost got avail %0b want 0", avail); end
    endtask

    task automatic test_reset_mid_frame();
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
        checks++; if (avail !== 1'b1) begin errors++; $display("FAIL rmid_pre_avail got %0b want 1", avail); end
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b0, 1'b1);
        drive_bit(1'b0, 1'b1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_pre_busy got %0b want 1", busy); end
        rst = 1'b1;
        rx = 1'b1;
        @(negedge clk);
        checks++; if ({data, perr, ferr, avail, overrun, brk, busy, tmo} !== 15'b0)
            begin errors++; $display("FAIL rmid_outputs got %b want 0", {data, perr, ferr, avail, overrun, brk, busy, tmo}); end
        rst = 1'b0;
        idle_bits(2);
        checks++; if (avail !== 1'b0) begin errors++; $display("FAIL rmid_no_push got %0b want 0", avail); end
        send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1);
        checks++; if (data !== 8'h81) begin errors++; $display("FAIL rmid_next_data got %h want 81", data); end
        checks++; if ({avail, perr, ferr} !== 3'b100) begin errors++; $display("FAIL rmid_next_flags got %b want 100", {avail, perr, ferr}); end
        pulse_ack();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_frame_err();
        test_glitch();
        test_break();
        test_back_to_back_overrun();
        test_reset_mid_frame();
        checks++; if (tmo_cycles !== 0) begin errors++; $display("FAIL timeout_tied got %0d want 0", tmo_cycles); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
